// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master MEM port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_arbiter_pkg;

    // KV10 datapath widths: 36-bit word, 22-bit physical address.
    localparam int WORD_W  = 36;
    localparam int PADDR_W = 22;

    // Requester count and one-hot bit indices of the arbiter state.
    // Cache and DMA instantiation sites use these to pick their port slot.
    localparam int NUM_RQ   = 2;
    localparam int ARB_IDLE = 0;
    localparam int ARB_GNT0 = 1;
    localparam int ARB_GNT1 = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'(1 << ARB_IDLE),
        ST_GNT0 = 3'(1 << ARB_GNT0),
        ST_GNT1 = 3'(1 << ARB_GNT1)
    } arb_state_t;

    // Place a single MEM response bit in the slot of requester idx;
    // the other slot is always 0.
    function automatic logic [0:NUM_RQ-1] route(input logic v, input logic idx);
        logic [0:NUM_RQ-1] r;
        r      = '0;
        r[idx] = v;
        return r;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Watchdog counter: counts enabled cycles, pulses expire on the cycle the count reaches timeout-1.
// Latency: expire is combinational from the registered count and enable.
// Backpressure: none; clear has priority over counting, expire restarts the count.
//
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   clear        : return count to 0 (highest priority)
//   enable       : count this cycle
//   expire       : one-cycle pulse when an enabled cycle finds count == timeout-1
//
// tbits must be wide enough to hold timeout-1; timeout must be >= 1.
module mem_watchdog #(
    parameter int timeout = 255,
    parameter int tbits   = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [tbits-1:0] count;

    assign expire = enable && (count == tbits'(timeout - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one MEM port between the cache (rq 0) and I/O DMA (rq 1).
// Latency: grant registered (request in cycle N, mem strobe in N+1); acks/nxm routed back same cycle.
// Backpressure: level requests held until ack/nxm; lock keeps the grant for bursts; watchdog turns a lost ack into nxm.
//
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   rq_addr/rq_wdata [0:1]            : per-requester address and write data
//   rq_read/rq_write/rq_lock [0:1]    : per-requester level request and burst lock
//   rq_rdata                          : MEM read data, broadcast while a grant is held
//   rq_read_ack/rq_write_ack/rq_nxm   : MEM responses, routed to the granted requester only
//   mem_addr/mem_write_data           : to MEM, from the granted requester
//   mem_read/mem_write                : to MEM, from the granted requester's strobes
//   mem_read_data                     : from MEM
//   mem_read_ack/mem_write_ack/mem_nxm: from MEM, one-cycle pulses
//   busy                              : a grant is held
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int timeout = 255,
    parameter int tbits   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PADDR_W-1:0] rq_addr  [0:NUM_RQ-1],
    input  logic [WORD_W-1:0]  rq_wdata [0:NUM_RQ-1],
    input  logic [0:NUM_RQ-1]  rq_read,
    input  logic [0:NUM_RQ-1]  rq_write,
    input  logic [0:NUM_RQ-1]  rq_lock,
    output logic [WORD_W-1:0]  rq_rdata,
    output logic [0:NUM_RQ-1]  rq_read_ack,
    output logic [0:NUM_RQ-1]  rq_write_ack,
    output logic [0:NUM_RQ-1]  rq_nxm,
    output logic [PADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0]  mem_write_data,
    output logic               mem_read,
    output logic               mem_write,
    input  logic [WORD_W-1:0]  mem_read_data,
    input  logic               mem_read_ack,
    input  logic               mem_write_ack,
    input  logic               mem_nxm,
    output logic               busy
);

    arb_state_t state, state_nxt;
    logic       rr, rr_nxt;          // last requester served

    logic [0:NUM_RQ-1] req;
    logic              granted;
    logic              gi;           // index of the granted requester
    logic              g_read, g_write, strobe;
    logic              ack_any, nxm_any;
    logic              wd_clear, wd_enable, wd_expire;

    assign req     = rq_read | rq_write;
    assign granted = (state != ST_IDLE);
    assign gi      = state[ARB_GNT1];
    assign busy    = granted;

    // Read wins if a requester illegally raises both strobes.
    assign g_read  = granted && rq_read[gi];
    assign g_write = granted && rq_write[gi] && !rq_read[gi];
    assign strobe  = g_read || g_write;

    // MEM side: straight from the granted requester, all zero when idle
    // (and therefore zero the moment reset forces IDLE).
    assign mem_read       = g_read;
    assign mem_write      = g_write;
    assign mem_addr       = granted ? rq_addr[gi]  : '0;
    assign mem_write_data = granted ? rq_wdata[gi] : '0;

    // Requester side: responses only ever reach the grant holder; a stray
    // ack while idle is dropped.
    assign ack_any      = mem_read_ack || mem_write_ack;
    assign nxm_any      = mem_nxm || wd_expire;
    assign rq_rdata     = granted ? mem_read_data : '0;
    assign rq_read_ack  = route(granted && mem_read_ack,  gi);
    assign rq_write_ack = route(granted && mem_write_ack, gi);
    assign rq_nxm       = route(granted && nxm_any,       gi);

    // Watchdog runs only while a strobe is actually outstanding. Between
    // locked burst beats the strobe is low, so the count freezes instead of
    // clearing; any completion or loss of grant clears it.
    assign wd_enable = strobe && !ack_any && !mem_nxm;
    assign wd_clear  = !granted || ack_any || mem_nxm;

    mem_watchdog #(
        .timeout (timeout),
        .tbits   (tbits)
    ) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expire  (wd_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            rr    <= 1'b1;               // requester 0 wins the first tie
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        case (state)
            ST_IDLE: begin
                if (req[0] && req[1]) begin
                    state_nxt = rr ? ST_GNT0 : ST_GNT1;
                end else if (req[0]) begin
                    state_nxt = ST_GNT0;
                end else if (req[1]) begin
                    state_nxt = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (ack_any || nxm_any) begin
                    rr_nxt = gi;
                    // nxm (memory or watchdog) always breaks a lock; a
                    // pending peer takes over without a dead cycle.
                    if (!nxm_any && rq_lock[gi]) begin
                        state_nxt = state;
                    end else if (req[~gi]) begin
                        state_nxt = gi ? ST_GNT0 : ST_GNT1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (!req[gi] && !rq_lock[gi]) begin
                    // Abort, or end of a locked burst: release without
                    // touching rr so fairness is unaffected.
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
